// File: rtl/gray_sync_bank.sv
// Bank of independent Gray-code synchronisers: each channel runs a DEPTH-flop chain,
// then a compare stage that decodes to binary, pulses on change and counts multi-bit jumps.

module gsb_lane #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 2,
  parameter int BIN_IN = 0,
  parameter int CNT_W  = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] data_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] bin_o,
  output logic             upd_o,
  output logic             err_o,
  output logic [CNT_W-1:0] err_cnt_o
);
  localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [WIDTH-1:0] stage_in;

  generate
    if (BIN_IN != 0) begin : g_enc
      logic [WIDTH-1:0] enc_q, enc_d;
      always_comb enc_d = data_i ^ (data_i >> 1);
      always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) enc_q <= '0;
        else         enc_q <= enc_d;
      assign stage_in = enc_q;
    end else begin : g_raw
      assign stage_in = data_i;
    end
  endgenerate

  logic [DEPTH-1:0][WIDTH-1:0] chain_q, chain_d;
  logic [WIDTH-1:0] prev_q, prev_d, bin_q, bin_d, chain_g, diff;
  logic             upd_q, upd_d, err_q, err_d, chg, multi;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb chain_d = {chain_q[DEPTH-2:0], stage_in};

  assign chain_g = chain_q[DEPTH-1];
  assign diff    = chain_g ^ prev_q;
  assign chg     = |diff;
  // Clearing the lowest set bit leaves something only if two or more bits differ.
  assign multi   = |(diff & (diff - ONE_W));

  always_comb begin
    prev_d = prev_q;
    bin_d  = bin_q;
    upd_d  = chg;
    err_d  = err_q;
    cnt_d  = cnt_q;
    if (chg) begin
      prev_d = chain_g;
      bin_d  = gray2bin(chain_g);
    end
    // A jump landing in the clear cycle survives as a fresh single error.
    if (clear_i) begin
      err_d = multi;
      cnt_d = multi ? ONE_C : '0;
    end else if (multi) begin
      err_d = 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + ONE_C;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chain_q <= '0;
      prev_q  <= '0;
      bin_q   <= '0;
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      chain_q <= chain_d;
      prev_q  <= prev_d;
      bin_q   <= bin_d;
      upd_q   <= upd_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bin_o     = bin_q;
  assign upd_o     = upd_q;
  assign err_o     = err_q;
  assign err_cnt_o = cnt_q;
endmodule

module gray_sync_bank #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 2,
  parameter int CH     = 4,
  parameter int BIN_IN = 0,
  parameter int CNT_W  = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [CH*WIDTH-1:0] data_i,
  input  logic                clear_i,
  output logic [CH*WIDTH-1:0] bin_o,
  output logic [CH-1:0]       upd_o,
  output logic [CH-1:0]       err_o,
  output logic [CH*CNT_W-1:0] err_cnt_o
);
  generate
    for (genvar c = 0; c < CH; c++) begin : g_lane
      gsb_lane #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BIN_IN(BIN_IN), .CNT_W(CNT_W)) u_lane (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .data_i    (data_i[c*WIDTH +: WIDTH]),
        .clear_i   (clear_i),
        .bin_o     (bin_o[c*WIDTH +: WIDTH]),
        .upd_o     (upd_o[c]),
        .err_o     (err_o[c]),
        .err_cnt_o (err_cnt_o[c*CNT_W +: CNT_W])
      );
    end
  endgenerate
endmodule

// File: doc/gray_sync_bank.md
GRAY_SYNC_BANK -- requirements
Module: gray_sync_bank

Interface
REQ-001 Parameter WIDTH, default 8: bits per channel.
REQ-002 Parameter DEPTH, default 2, legal 2..4: synchroniser flop stages per channel.
REQ-003 Parameter CH, default 4, legal 1..16: number of independent channels.
REQ-004 Parameter BIN_IN, default 0: 0 means data_i is Gray code from a foreign domain; 1 means data_i is binary, synchronous to clk_i, and is Gray-encoded in an input register before the chain.
REQ-005 Parameter CNT_W, default 8: width of each per-channel error counter.
REQ-006 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-007 rst_ni  input  1  asynchronous, active-low reset.
REQ-008 data_i  input  CH*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
REQ-009 clear_i  input  1  synchronous clear of err_o and err_cnt_o, all channels.
REQ-010 bin_o  output  CH*WIDTH  synchronised value per channel, binary, registered.
REQ-011 upd_o  output  CH  one-cycle pulse per channel when bin_o changes.
REQ-012 err_o  output  CH  sticky flag: illegal Gray transition seen on the channel.
REQ-013 err_cnt_o  output  CH*CNT_W  saturating count of illegal transitions per channel.

Function
REQ-014 Each channel SHALL run an identical, independent pipeline; no cross-channel state.
REQ-015 BIN_IN=1: an encode register SHALL capture g = b ^ (b >> 1) each cycle. BIN_IN=0: data_i SHALL feed stage 0 directly.
REQ-016 The sync chain SHALL have DEPTH flops per channel, shifting every cycle, with no enable and no combinational logic between stages.
REQ-017 A compare stage SHALL hold prev_g, the last Gray value taken from the chain output (chain_g).
REQ-018 Each cycle the compare stage SHALL compute d = popcount(chain_g ^ prev_g).
REQ-019 d=0: bin_o, prev_g and err state SHALL hold; upd_o SHALL be 0.
REQ-020 d=1: prev_g <= chain_g; bin_o <= gray2bin(chain_g); upd_o SHALL be 1 for one cycle.
REQ-021 gray2bin SHALL be: b[W-1] = g[W-1]; b[i] = b[i+1] ^ g[i].
REQ-022 d>=2: prev_g and bin_o SHALL still update, upd_o SHALL pulse, and err_o SHALL be set.
REQ-023 d>=2: err_cnt SHALL increment and saturate at 2^CNT_W-1, never wrapping.
REQ-024 Latency from a stable data_i to the updated bin_o SHALL be exactly DEPTH+1 clk_i edges (BIN_IN=0) or DEPTH+2 edges (BIN_IN=1); upd_o SHALL assert in the same cycle bin_o changes.
REQ-025 Counter wrap: a Gray transition from max to 0 is a single-bit change and SHALL be treated as d=1 with no error.
REQ-026 clear_i=1 SHALL zero err_o and err_cnt_o on the next edge.
REQ-027 If clear_i coincides with d>=2 on a channel, that channel SHALL end with err_o=1 and err_cnt=1.
REQ-028 clear_i SHALL NOT affect the sync chain, prev_g, bin_o or upd_o.
REQ-029 All outputs SHALL be driven directly from flops.

Reset
REQ-030 rst_ni low SHALL immediately clear the encode register, all chain stages, prev_g, bin_o, upd_o, err_o and err_cnt_o to 0, regardless of clk_i.
REQ-031 Reset asserted mid-operation SHALL discard in-flight values; after release, prev_g=0 is the reference for the first comparison.
REQ-032 Release of rst_ni SHALL be treated as synchronous to clk_i (deasserted externally through a reset synchroniser); the first active edge follows release.

Verification
REQ-033 Stepping: WIDTH=4, DEPTH=2, BIN_IN=0; data_i ch0 steps Gray 0000->0001 -> bin_o ch0=1 and upd_o[0] pulse exactly 3 edges later; err_o=0.
REQ-034 Illegal transition: ch1 jumps Gray 0000->0011 -> bin_o ch1=2, upd_o[1] pulse, err_o[1]=1, err_cnt ch1=1; ch0 unaffected.
REQ-035 Saturation and clear: CNT_W=2, five illegal jumps -> err_cnt=3 held; clear_i pulse -> err_o=0, cnt=0; clear_i together with an illegal jump -> err_o=1, cnt=1.
REQ-036 Binary mode: BIN_IN=1, binary count 0..15..0 on all channels -> bin_o tracks the count 4 edges behind; 15->0 wrap gives upd_o and no error; err_cnt stays 0.
REQ-037 Async reset: drive rst_ni low between clock edges while bin_o=9 -> all outputs are 0 before the next edge; after release with data_i=Gray 1 -> bin_o=1 after DEPTH+1 edges, no error.
REQ-038 Parameter sweep: DEPTH in {2,3,4}, CH in {1,16}; randomised single-bit Gray walks -> bin_o matches the model at DEPTH+1 latency and err_o never sets.
